i2c_target_regs: RTL and testbench

- I2C target (slave) holding a small byte-addressed register bank. It is the far end of the SoC's i2c_0 master and is used for board-level tests and for a companion FPGA peripheral.
- Connects to the open-drain pad pair with the same convention as the SoC: separate inputs, plus an output-enable that pulls the line low.
- Game logic reads the bank through a local port and gets a strobe on every I2C write.

---
 rtl/i2c_target_regs.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regs
// Brief    : I2C target with a byte-addressed register bank and local read port
// Revision : 1.0  initial release
// ============================================================================
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         ADDR_W      = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [7:0]        loc_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_WR_PTR   = 4'd3,
    S_PTR_ACK  = 4'd4,
    S_WR_DATA  = 4'd5,
    S_DATA_ACK = 4'd6,
    S_RD_DATA  = 4'd7,
    S_RD_ACK   = 4'd8,
    S_IGNORE   = 4'd9
  } state_t;

  // [0] first sync stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0]        scl_q, scl_d;
  logic [2:0]        sda_q, sda_d;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        bank_q [DEPTH];
  logic [7:0]        bank_d [DEPTH];

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

  always_comb begin
    scl_d       = {scl_q[1:0], scl_in};
    sda_d       = {sda_q[1:0], sda_in};
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    ack_d       = ack_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    bank_d      = bank_q;

    if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = 4'd0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_IGNORE: begin
        end
        // Receive states count rising edges 0..8; the byte is acted on at the fall after the 8th bit
        S_ADDR, S_WR_PTR, S_WR_DATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_q[1]};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == S_ADDR) begin
              if (shift_q[7:1] == TARGET_ADDR) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                state_d  = S_ADDR_ACK;
              end else begin
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = S_IGNORE;
              end
            end else if (state_q == S_WR_PTR) begin
              ptr_d    = shift_q[ADDR_W-1:0];
              sda_oe_d = 1'b1;
              state_d  = S_PTR_ACK;
            end else begin
              bank_d[ptr_q] = shift_q;
              wr_strobe_d   = 1'b1;
              wr_addr_d     = ptr_q;
              wr_data_d     = shift_q;
              ptr_d         = ptr_q + 1'b1;
              sda_oe_d      = 1'b1;
              state_d       = S_DATA_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (shift_q[0]) begin
              shift_d  = bank_q[ptr_q];
              sda_oe_d = ~bank_q[ptr_q][7];
              state_d  = S_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_WR_PTR;
            end
          end
        end
        S_PTR_ACK, S_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              state_d  = S_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            ack_d = sda_q[1];
          end else if (scl_fall) begin
            cnt_d = 4'd0;
            if (!ack_q) begin
              shift_d  = bank_q[ptr_q];
              sda_oe_d = ~bank_q[ptr_q][7];
              state_d  = S_RD_DATA;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IGNORE;
            end
          end
        end
        default: begin
          sda_oe_d = 1'b0;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      // Synchronizers start at the idle bus level so reset release cannot fake a START
      scl_q       <= 3'b111;
      sda_q       <= 3'b111;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= 8'h00;
      end
    end else begin
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign loc_rdata = bank_q[loc_addr];

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// Bench for i2c_target_regs: bit-banged I2C master, transaction-level bank model,
// table-driven write vectors, hand-written corner sequences and randomized traffic.
module tb_i2c_target_regs;
  localparam int         QTR = 8;
  localparam logic [6:0] DEV = 7'h42;

  typedef struct {
    logic [7:0]  dev;
    logic [31:0] bytes;
    int          n;
    int          exp_acks;
    int          exp_strobes;
  } wvec_t;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in, sda_oe, wr_strobe, busy;
  logic [3:0] loc_addr = 4'd0;
  logic [3:0] wr_addr;
  logic [7:0] loc_rdata, wr_data;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target_regs #(.TARGET_ADDR(DEV), .ADDR_W(4)) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .sda_oe       (sda_oe),
    .loc_addr     (loc_addr),
    .loc_rdata    (loc_rdata),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mbank [16];
  int         mptr = 0;
  logic [11:0] slog [1024];
  int         strobe_n = 0;
  int         oe_cnt = 0;

  always @(negedge clk_clk) begin
    if (wr_strobe === 1'b1 && strobe_n < 1024) begin
      slog[strobe_n] = {wr_addr, wr_data};
      strobe_n++;
    end
    if (sda_oe === 1'b1) oe_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (QTR) @(negedge clk_clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic wbit(input logic b, output logic bus);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    bus = sda_in; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic bus;
    for (int i = 7; i >= 0; i--) wbit(b[i], bus);
    wbit(1'b1, bus);
    ack = ~bus;
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic bus;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wbit(1'b1, bus);
      d = {d[6:0], bus};
    end
    wbit(~mack, bus);
  endtask

  task automatic check_bank(input string tag);
    for (int a = 0; a < 16; a++) begin
      loc_addr = 4'(a);
      #1;
      chk($sformatf("%s loc[%0d]", tag, a), {24'h0, loc_rdata}, {24'h0, mbank[a]});
    end
  endtask

  // Write transaction: first byte sets the pointer, the rest are stored with auto-increment
  task automatic do_write(input logic [7:0] dev, input logic [31:0] bytes, input int n,
                          input int exp_acks, input int exp_strobes, input string tag);
    logic a;
    logic [7:0] b;
    int acks, s0, o0;
    bit match;
    acks = 0; s0 = strobe_n; o0 = oe_cnt;
    match = (dev[7:1] == DEV) && (dev[0] == 1'b0);
    i2c_start();
    wbyte(dev, a);
    if (a) acks++;
    chk({tag, " busy after addr"}, {31'h0, busy}, {31'h0, match});
    for (int i = 0; i < n; i++) begin
      wbyte(bytes[8*(3-i) +: 8], a);
      if (a) acks++;
    end
    i2c_stop();
    wait_q();
    chk({tag, " acks"}, acks, exp_acks);
    chk({tag, " strobes"}, strobe_n - s0, exp_strobes);
    chk({tag, " busy after stop"}, {31'h0, busy}, 32'h0);
    if (!match) chk({tag, " sda pulled"}, oe_cnt - o0, 32'h0);
    if (match && n > 0) begin
      mptr = int'(bytes[27:24]);
      for (int i = 1; i < n; i++) begin
        b = bytes[8*(3-i) +: 8];
        chk($sformatf("%s strobe%0d", tag, i), {20'h0, slog[s0+i-1]}, {20'h0, 4'(mptr), b});
        mbank[mptr] = b;
        mptr = (mptr + 1) % 16;
      end
    end
    check_bank(tag);
  endtask

  // Read transaction, optionally preceded by a pointer write and repeated START
  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n, input string tag);
    logic a;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      wbyte(8'h84, a);
      chk({tag, " wr addr ack"}, {31'h0, a}, 32'h1);
      wbyte(p, a);
      chk({tag, " ptr ack"}, {31'h0, a}, 32'h1);
      mptr = int'(p[3:0]);
      i2c_start();
    end
    wbyte(8'h85, a);
    chk({tag, " rd addr ack"}, {31'h0, a}, 32'h1);
    for (int i = 0; i < n; i++) begin
      rbyte(i != n - 1, d);
      chk($sformatf("%s byte%0d", tag, i), {24'h0, d}, {24'h0, mbank[mptr]});
      mptr = (mptr + 1) % 16;
    end
    chk({tag, " busy after nack"}, {31'h0, busy}, 32'h0);
    i2c_stop();
    wait_q();
  endtask

  initial begin
    wvec_t vecs[5];
    logic a, bus;
    int s0, kind, n;
    logic [7:0] dev;

    vecs[0] = '{8'h84, 32'h03A55A00, 3, 4, 2};   // burst at pointer 3
    vecs[1] = '{8'h84, 32'h0F112200, 3, 4, 2};   // wraps 15 -> 0
    vecs[2] = '{8'h86, 32'h01000000, 1, 0, 0};   // wrong address
    vecs[3] = '{8'h00, 32'h05770000, 2, 0, 0};   // general call
    vecs[4] = '{8'h84, 32'hF79C0000, 2, 3, 1};   // upper pointer bits ignored

    for (int i = 0; i < 16; i++) mbank[i] = 8'h00;

    // Reset with SDA held low by the master
    sda_m = 1'b0;
    repeat (5) @(negedge clk_clk);
    chk("reset sda_oe", {31'h0, sda_oe}, 32'h0);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset wr_strobe", {31'h0, wr_strobe}, 32'h0);
    chk("reset wr_addr", {28'h0, wr_addr}, 32'h0);
    chk("reset wr_data", {24'h0, wr_data}, 32'h0);
    check_bank("reset");
    sda_m = 1'b1;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    wait_q();

    for (int v = 0; v < 5; v++)
      do_write(vecs[v].dev, vecs[v].bytes, vecs[v].n, vecs[v].exp_acks, vecs[v].exp_strobes,
               $sformatf("vec%0d", v));

    // Wrap read across 15 -> 0 using pointer write + repeated START
    do_read(1'b1, 8'h0F, 2, "wrap read");

    // Abort: partial data byte must be discarded
    s0 = strobe_n;
    i2c_start();
    wbyte(8'h84, a);
    chk("abort addr ack", {31'h0, a}, 32'h1);
    wbyte(8'h02, a);
    chk("abort ptr ack", {31'h0, a}, 32'h1);
    mptr = 2;
    for (int i = 0; i < 5; i++) wbit(1'b1, bus);
    i2c_stop();
    wait_q();
    chk("abort strobes", strobe_n - s0, 32'h0);
    chk("abort sda_oe", {31'h0, sda_oe}, 32'h0);
    chk("abort busy", {31'h0, busy}, 32'h0);
    check_bank("abort");
    do_read(1'b0, 8'h00, 1, "abort readback");

    // Reset while the target drives a 0 data bit
    do_write(8'h84, 32'h053C0000, 2, 3, 1, "pre-reset");
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'h05, a);
    i2c_start();
    wbyte(8'h85, a);
    chk("rmid addr ack", {31'h0, a}, 32'h1);
    chk("rmid driving 0", {31'h0, sda_oe}, 32'h1);
    reset_reset_n = 1'b0;
    @(posedge clk_clk);
    @(negedge clk_clk);
    chk("rmid sda released", {31'h0, sda_oe}, 32'h0);
    chk("rmid busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
    mptr = 0;
    wait_q();
    do_write(8'h84, 32'h09E10000, 2, 3, 1, "post-reset");

    // Randomized traffic against the bank model
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      if (kind == 0) begin
        do_write(8'h84, $urandom(), n, n + 1, n - 1, $sformatf("rnd%0d wr", t));
      end else if (kind == 1) begin
        dev = {7'(7'h43 + 7'($urandom_range(0, 60))), 1'b0};
        do_write(dev, $urandom(), n, 0, 0, $sformatf("rnd%0d bad", t));
      end else begin
        do_read(1'($urandom_range(0, 1)), 8'($urandom()), $urandom_range(1, 3),
                $sformatf("rnd%0d rd", t));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
